// File: rtl/ir_fetch_unit_if.sv
// ir_fetch_unit_if: memory bus between the fetch unit (master) and memory (slave).
interface ir_fetch_unit_if #(parameter int AW = 12, parameter int DW = 12);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  modport master (output mem_addr, mem_rd, mem_wr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_addr, mem_rd, mem_wr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/ir_fetch_unit.sv
// ir_fetch_unit: PDP-8 instruction fetch and effective-address formation.
// Define AUTOINDEX_EN to enable autoindex increment and write-back of locations 0010-0017.
module ir_fetch_unit #(parameter int AW = 12, parameter int DW = 12) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] pc,
  ir_fetch_unit_if.master bus,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] pclatched,
  output logic [AW-1:0] ea,
  output logic          ea_valid,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, FETCH, CALC, INDRD, AIWR, DONE} state_t;
  state_t state, nxt;
  logic [AW-1:0] p;
  logic auto_loc, is_mri;
  assign p = ir[7] ? {pclatched[AW-1:7], ir[6:0]} : {{(AW-7){1'b0}}, ir[6:0]};
  assign is_mri = ir[11:9] < 3'd6;
`ifdef AUTOINDEX_EN
  assign auto_loc = p[AW-1:3] == (AW-3)'(1);
`else
  assign auto_loc = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = bus.mem_ack ? CALC : FETCH;
      CALC:    nxt = (is_mri && ir[8]) ? INDRD : DONE;
      INDRD:   nxt = bus.mem_ack ? (auto_loc ? AIWR : DONE) : INDRD;
      AIWR:    nxt = bus.mem_ack ? DONE : AIWR;
      default: nxt = IDLE;
    endcase
  end
  // Requests are decoded from state alone so reset drops them asynchronously.
  always_comb begin
    bus.mem_rd = state == FETCH || state == INDRD;
    bus.mem_addr = state == FETCH ? pclatched : p;
`ifdef AUTOINDEX_EN
    bus.mem_wr = state == AIWR;
    bus.mem_wdata = state == AIWR ? ea : '0;
`else
    bus.mem_wr = 1'b0;
    bus.mem_wdata = '0;
`endif
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir <= '0;
      pclatched <= '0;
      ea <= '0;
      ea_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pclatched <= pc;
          ea_valid <= 1'b0;
        end
        FETCH: if (bus.mem_ack) ir <= bus.mem_rdata;
        CALC: if (is_mri && !ir[8]) begin
          ea <= p;
          ea_valid <= 1'b1;
        end
        INDRD: if (bus.mem_ack) begin
          ea <= auto_loc ? bus.mem_rdata + 12'd1 : bus.mem_rdata;
          ea_valid <= !auto_loc;
        end
        AIWR: if (bus.mem_ack) ea_valid <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb_ir_fetch_unit: scoreboard bench with a randomised memory responder and an instruction-level model.
module tb_ir_fetch_unit;
`ifdef AUTOINDEX_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif
  typedef struct {
    logic [11:0] ir, pcl, ea, waddr, wdata;
    bit eav, wr;
    int lat;
  } exp_t;

  logic clk = 0, reset = 1, start = 0;
  logic [11:0] pc_in = 0;
  logic [11:0] ir, pclatched, ea;
  logic ea_valid, busy, done;
  logic [11:0] mem [4096];
  exp_t q[$];
  logic [23:0] act_w[$];
  int nchk = 0, nfail = 0, lat = 0, waits_acc = 0, fixed_wait = -1;
  bit stall_on = 0;

  ir_fetch_unit_if bus();
  ir_fetch_unit dut (.clk(clk), .reset(reset), .start(start), .pc(pc_in), .bus(bus), .ir(ir),
    .pclatched(pclatched), .ea(ea), .ea_valid(ea_valid), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  function automatic logic [11:0] page_of(input logic [11:0] p, input logic [11:0] w);
    return (w & 12'o200) != 0 ? (p & 12'o7600) | (w & 12'o177) : w & 12'o177;
  endfunction

  function automatic exp_t model(input logic [11:0] p);
    exp_t e;
    logic [11:0] pa, ptr;
    e.ir = mem[p]; e.pcl = p; e.ea = 0; e.eav = 0; e.wr = 0; e.waddr = 0; e.wdata = 0;
    pa = page_of(p, e.ir);
    if (e.ir / 512 >= 6) e.lat = 3;
    else if ((e.ir & 12'o400) == 0) begin e.ea = pa; e.eav = 1; e.lat = 3; end
    else begin
      ptr = mem[pa];
      e.eav = 1;
      if (AI && pa >= 8 && pa <= 15) begin
        e.ea = 12'((int'(ptr) + 1) % 4096); e.wr = 1; e.waddr = pa; e.wdata = e.ea; e.lat = 5;
      end else begin e.ea = ptr; e.lat = 4; end
    end
    return e;
  endfunction

  // Memory slave: random or forced ack delay, stability of waiting requests.
  bit waiting = 0;
  int cnt = 0, target = 0;
  logic [11:0] r_addr, r_wdata;
  logic r_rd, r_wr;
  always @(negedge clk) begin
    bus.mem_ack = 0;
    bus.mem_rdata = 12'($urandom);
    if (reset || !(bus.mem_rd || bus.mem_wr)) waiting = 0;
    else begin
      chk("one_req", {11'b0, bus.mem_rd & bus.mem_wr}, 12'd0);
      if (!waiting) begin
        r_addr = bus.mem_addr; r_rd = bus.mem_rd; r_wr = bus.mem_wr; r_wdata = bus.mem_wdata;
        target = fixed_wait >= 0 ? fixed_wait : int'($urandom_range(0, 2));
        if (stall_on && (AI ? bus.mem_wr : (bus.mem_rd && bus.mem_addr == 12'o10))) target = 100000;
        cnt = 0; waiting = 1;
      end else begin
        chk("stable_addr", bus.mem_addr, r_addr);
        chk("stable_rdwr", {10'b0, bus.mem_rd, bus.mem_wr}, {10'b0, r_rd, r_wr});
        chk("stable_wdata", bus.mem_wdata, r_wdata);
      end
      if (cnt == target) begin
        bus.mem_ack = 1;
        if (bus.mem_wr) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          act_w.push_back({bus.mem_addr, bus.mem_wdata});
        end else bus.mem_rdata = mem[bus.mem_addr];
        waiting = 0;
      end else begin cnt++; waits_acc++; end
    end
  end

  // Monitor: compares each completed fetch against the queued expectation.
  exp_t m;
  always @(negedge clk) begin
    if (reset) lat = 0;
    else begin
      if (busy) lat++;
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 12'd1, 12'd0);
        else begin
          m = q.pop_front();
          chk("ir", ir, m.ir);
          chk("pclatched", pclatched, m.pcl);
          chk("ea_valid", {11'b0, ea_valid}, {11'b0, m.eav});
          if (m.eav) chk("ea", ea, m.ea);
          chk("latency", 12'(lat), 12'(m.lat + waits_acc));
          chk("write_count", 12'(act_w.size()), 12'(m.wr));
          if (m.wr && act_w.size() > 0) begin
            chk("write_addr", act_w[0][23:12], m.waddr);
            chk("write_data", act_w[0][11:0], m.wdata);
          end
          act_w.delete();
        end
        lat = 0; waits_acc = 0;
      end
    end
  end

  task automatic run(input logic [11:0] p, input bit extra);
    q.push_back(model(p));
    @(negedge clk); start = 1; pc_in = p;
    @(negedge clk);
    if (extra) begin pc_in = p ^ 12'o7777; @(negedge clk); end
    start = 0;
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    if (busy) chk("timeout", 12'd1, 12'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"}, {11'b0, bus.mem_rd}, 12'd0);
    chk({tag, "_wr"}, {11'b0, bus.mem_wr}, 12'd0);
    chk({tag, "_busy"}, {11'b0, busy}, 12'd0);
    chk({tag, "_done"}, {11'b0, done}, 12'd0);
    chk({tag, "_eav"}, {11'b0, ea_valid}, 12'd0);
    chk({tag, "_ir"}, ir, 12'd0);
    chk({tag, "_pcl"}, pclatched, 12'd0);
    chk({tag, "_ea"}, ea, 12'd0);
  endtask

  initial begin
    logic [11:0] p, w;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    #12 chk_idle("reset");
    @(negedge clk); reset = 0;
    mem[12'o200] = 12'o1205; run(12'o200, 0);
    mem[12'o200] = 12'o1605; mem[12'o205] = 12'o3000; run(12'o200, 0);
    mem[12'o400] = 12'o1410; mem[12'o10] = 12'o0777; run(12'o400, 0);
    mem[12'o10] = 12'o7777; run(12'o400, 0);
    mem[12'o5] = 12'o1610; mem[12'o10] = 12'o0100; run(12'o5, 0);
    mem[12'o300] = 12'o7200; run(12'o300, 1);
    for (int n = 0; n < 60; n++) begin
      p = 12'($urandom);
      w = 12'($urandom);
      if ($urandom_range(0, 2) == 0) w = (w & 12'o7600) | 12'(8 + $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) w = w & 12'o5777;
      mem[p] = w;
      if ($urandom_range(0, 3) == 0 && page_of(p, w) != p) mem[page_of(p, w)] = 12'o7777;
      run(p, n % 7 == 0);
    end
    fixed_wait = 4;
    mem[12'o200] = 12'o1605; mem[12'o205] = 12'o2345; run(12'o200, 0);
    fixed_wait = 0; stall_on = 1;
    mem[12'o400] = 12'o1410; mem[12'o10] = 12'o0777;
    @(negedge clk); start = 1; pc_in = 12'o400;
    @(negedge clk); start = 0;
    for (int i = 0; i < 50 && !(AI ? bus.mem_wr : (bus.mem_rd && bus.mem_addr == 12'o10)); i++) @(negedge clk);
    chk("reached_stall", {11'b0, busy}, 12'd1);
    @(negedge clk); #2 reset = 1;
    #1 chk_idle("abort");
    chk("abort_mem", mem[12'o10], 12'o0777);
    chk("abort_writes", 12'(act_w.size()), 12'd0);
    @(negedge clk); @(negedge clk);
    reset = 0; stall_on = 0; fixed_wait = -1; waits_acc = 0; act_w.delete();
    mem[12'o300] = 12'o7200; run(12'o300, 0);
    mem[12'o200] = 12'o1205; run(12'o200, 0);
    chk("queue_empty", 12'(q.size()), 12'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
